// File: rtl/sync_fifo_if.sv
// Handshake and status bundle between a FIFO producer/consumer and sync_fifo.
// The master side drives requests; the slave side (the FIFO) drives data and status.
interface sync_fifo_if #(
    parameter int BUS_WIDTH     = 12,
    parameter int ADDRESS_WIDTH = 2
);
    logic                     write_enable;
    logic [BUS_WIDTH-1:0]     write_data;
    logic                     read_enable;
    logic [BUS_WIDTH-1:0]     read_data;
    logic                     read_valid;
    logic                     flush;
    logic                     clear_errors;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic                     almost_empty;
    logic [ADDRESS_WIDTH:0]   level;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output write_enable, write_data, read_enable, flush, clear_errors,
        input  read_data, read_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  write_enable, write_data, read_enable, flush, clear_errors,
        output read_data, read_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, level-based status flags,
// synchronous flush and sticky overflow/underflow error flags.
module sync_fifo #(
    parameter int BUS_WIDTH              = 12,
    parameter int ADDRESS_WIDTH          = 2,
    parameter int ALMOST_FULL_THRESHOLD  = (2**ADDRESS_WIDTH) - 1,
    parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
    input  logic        clock,
    input  logic        reset,
    sync_fifo_if.slave  bus
);
    localparam int DEPTH = 2**ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] DEPTH_LVL = (ADDRESS_WIDTH+1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH:0] AF_LVL    = (ADDRESS_WIDTH+1)'(ALMOST_FULL_THRESHOLD);
    localparam logic [ADDRESS_WIDTH:0] AE_LVL    = (ADDRESS_WIDTH+1)'(ALMOST_EMPTY_THRESHOLD);

    logic [BUS_WIDTH-1:0]     mem_q [DEPTH];
    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRESS_WIDTH:0]   level_q, level_d;
    logic [BUS_WIDTH-1:0]     read_data_q, read_data_d;
    logic                     read_valid_q, read_valid_d;
    logic                     overflow_q, overflow_d;
    logic                     underflow_q, underflow_d;

    logic full, empty, almost_full, almost_empty;
    logic wr_accept, rd_accept;

    // Status flags come only from the registered level, so accept decisions
    // see the flags as they stood at the edge.
    always_comb begin
        full         = (level_q == DEPTH_LVL);
        empty        = (level_q == '0);
        almost_full  = (level_q >= AF_LVL);
        almost_empty = (level_q <= AE_LVL);
        wr_accept    = bus.write_enable && !full  && !bus.flush;
        rd_accept    = bus.read_enable  && !empty && !bus.flush;
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        read_data_d  = read_data_q;
        read_valid_d = rd_accept;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + ADDRESS_WIDTH'(1);
            end
            if (rd_accept) begin
                rd_ptr_d    = rd_ptr_q + ADDRESS_WIDTH'(1);
                read_data_d = mem_q[rd_ptr_q];
            end
            case ({wr_accept, rd_accept})
                2'b10:   level_d = level_q + (ADDRESS_WIDTH+1)'(1);
                2'b01:   level_d = level_q - (ADDRESS_WIDTH+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Clear is applied before set, so a new error in the clearing cycle wins.
    always_comb begin
        overflow_d  = bus.clear_errors ? 1'b0 : overflow_q;
        underflow_d = bus.clear_errors ? 1'b0 : underflow_q;
        if (bus.write_enable && full && !bus.flush) begin
            overflow_d = 1'b1;
        end
        if (bus.read_enable && empty && !bus.flush) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage is not reset; discarding words only needs the pointers and level.
    always_ff @(posedge clock) begin
        if (wr_accept && !reset) begin
            mem_q[wr_ptr_q] <= bus.write_data;
        end
    end

    assign bus.read_data    = read_data_q;
    assign bus.read_valid   = read_valid_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = almost_full;
    assign bus.almost_empty = almost_empty;
    assign bus.level        = level_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 12: data word width in bits.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 2: depth DEPTH = 2**ADDRESS_WIDTH words.
REQ-003 SHALL have parameter ALMOST_FULL_THRESHOLD, default DEPTH-1: almost_full asserted when level >= this value.
REQ-004 SHALL have parameter ALMOST_EMPTY_THRESHOLD, default 1: almost_empty asserted when level <= this value.
REQ-005 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port write_enable  input  1  write request.
REQ-008 SHALL have port write_data  input  BUS_WIDTH  word to store.
REQ-009 SHALL have port read_enable  input  1  read request.
REQ-010 SHALL have port read_data  output  BUS_WIDTH  registered head word.
REQ-011 SHALL have port read_valid  output  1  read_data holds a word popped in the previous cycle.
REQ-012 SHALL have port flush  input  1  synchronous discard of all contents.
REQ-013 SHALL have port clear_errors  input  1  clears sticky error flags.
REQ-014 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-015 SHALL have port level  output  ADDRESS_WIDTH+1  current word count, 0..DEPTH.
REQ-016 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 SHALL accept a write when write_enable=1 and full=0 (flags as registered at that edge); word stored at write pointer, pointer increments modulo DEPTH.
REQ-018 SHALL accept a read when read_enable=1 and empty=0; head word registered into read_data, read pointer increments modulo DEPTH.
REQ-019 SHALL assert read_valid for exactly one cycle, the cycle after each accepted read; read_valid=0 otherwise.
REQ-020 SHALL hold read_data unchanged when no read is accepted.
REQ-021 SHALL reject writes while full=1, even if a read is accepted in the same cycle; rejected write sets overflow.
REQ-022 SHALL reject reads while empty=1, even if a write is accepted in the same cycle; rejected read sets underflow; read_valid stays 0.
REQ-023 SHALL accept simultaneous read and write when 0 < level < DEPTH; level unchanged.
REQ-024 SHALL update level: +1 on write-only accept, -1 on read-only accept, unchanged otherwise.
REQ-025 SHALL derive full (level==DEPTH), empty (level==0), almost_full, almost_empty combinationally from registered level.
REQ-026 SHALL preserve FIFO order across pointer wrap-around indefinitely.
REQ-027 SHALL, on flush=1, set level=0 and both pointers to 0 next cycle; read and write in same cycle are ignored and do not set error flags; read_valid=0 next cycle; read_data unchanged.
REQ-028 SHALL keep overflow/underflow set until clear_errors=1 or reset; if clear_errors and a new error coincide, flag ends set.

Reset
REQ-029 SHALL, with reset=1 at a rising edge, set pointers=0, level=0, read_valid=0, read_data=0, overflow=0, underflow=0; reset overrides all other inputs.
REQ-030 SHALL after reset present empty=1, full=0, almost_empty=1 (level 0 <= threshold), almost_full=0.
REQ-031 SHALL, on reset asserted mid-operation, discard all stored words; storage array contents need not be cleared.

Verification (BUS_WIDTH=12, ADDRESS_WIDTH=2, default thresholds)
REQ-032 SHALL verify: reset, write 0x001..0x004 -> level 1,2,3,4; almost_full at level 3; full at 4; then 4 reads -> read_data 0x001..0x004, each with read_valid one cycle after read_enable; empty at end.
REQ-033 SHALL verify: full, write 0xABC with read same cycle -> write rejected, overflow=1, level 3; subsequent reads return 0x002..0x004, never 0xABC.
REQ-034 SHALL verify: empty, read with write 0x055 same cycle -> underflow=1, read_valid=0, level=1; next read returns 0x055.
REQ-035 SHALL verify: 10 cycles simultaneous read/write at level 2 with incrementing data -> level stays 2, outputs in order across wrap.
REQ-036 SHALL verify: level 3, flush=1 with write_enable=1 -> level 0, empty=1, no overflow; then clear_errors=1 clears prior flags next cycle.
REQ-037 SHALL verify: reset asserted at level 2 with read_enable=1 -> next cycle level 0, read_valid=0, read_data=0, flags cleared.
